// File: rtl/addsub_rr_arbiter.sv
// rtl/addsub_rr_arbiter.sv - round-robin arbiter sharing one add/sub datapath
// Grants one requester per cycle and registers the result with valid/ready.

module adder_subtractor_dut #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             ovf_o
);
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] y_eff;

  // Subtract as x + ~y + 1 so carry out means "no borrow".
  assign y_eff    = sub_i ? ~y_i : y_i;
  assign sum      = {1'b0, x_i} + {1'b0, y_eff} + {{WIDTH{1'b0}}, sub_i};
  assign result_o = sum[WIDTH-1:0];
  assign cout_o   = sum[WIDTH];
  assign ovf_o    = sub_i ? ((x_i[WIDTH-1] != y_i[WIDTH-1]) && (result_o[WIDTH-1] != x_i[WIDTH-1]))
                          : ((x_i[WIDTH-1] == y_i[WIDTH-1]) && (result_o[WIDTH-1] != x_i[WIDTH-1]));
endmodule

module addsub_rr_arbiter #(
  parameter int WIDTH = 4,
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_x,
  input  logic [N_REQ*WIDTH-1:0] req_y,
  input  logic [N_REQ-1:0]       req_add_n,
  output logic [N_REQ-1:0]       gnt,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [WIDTH-1:0]       rsp_result,
  output logic                   rsp_cout,
  output logic                   rsp_ovf
);
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             rsp_ovf_q, rsp_ovf_d;

  logic             found;
  logic             gnt_any;
  logic             slot_free;
  logic [IDW-1:0]   sel;
  logic [WIDTH-1:0] x_mux, y_mux;
  logic             sub_mux;
  logic [WIDTH-1:0] alu_result;
  logic             alu_cout, alu_ovf;

  assign slot_free = !rsp_valid_q || rsp_ready;

  // Scan from ptr with wrap; works for non-power-of-two N_REQ.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = IDW'(idx);
      end
    end
  end

  assign gnt_any = found && slot_free && rst_n;
  assign gnt     = gnt_any ? (N_REQ'(1) << sel) : '0;

  assign x_mux   = req_x[int'(sel)*WIDTH +: WIDTH];
  assign y_mux   = req_y[int'(sel)*WIDTH +: WIDTH];
  assign sub_mux = req_add_n[sel];

  adder_subtractor_dut #(.WIDTH(WIDTH)) u_alu (
    .x_i      (x_mux),
    .y_i      (y_mux),
    .sub_i    (sub_mux),
    .result_o (alu_result),
    .cout_o   (alu_cout),
    .ovf_o    (alu_ovf)
  );

  always_comb begin
    ptr_d        = ptr_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_cout_d   = rsp_cout_q;
    rsp_ovf_d    = rsp_ovf_q;
    if (gnt_any) begin
      ptr_d        = (sel == IDW'(N_REQ - 1)) ? '0 : sel + IDW'(1);
      rsp_valid_d  = 1'b1;
      rsp_id_d     = sel;
      rsp_result_d = alu_result;
      rsp_cout_d   = alu_cout;
      rsp_ovf_d    = alu_ovf;
    end else if (rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_cout_q   <= rsp_cout_d;
      rsp_ovf_q    <= rsp_ovf_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_cout   = rsp_cout_q;
  assign rsp_ovf    = rsp_ovf_q;
endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// tb/tb_addsub_rr_arbiter.sv - directed bench for addsub_rr_arbiter
// Inputs change on the falling edge; outputs are checked before and #1 after the rising edge.

module tb_addsub_rr_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] req_x, req_y;
  logic [3:0]  req_add_n;
  logic [3:0]  gnt;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_result;
  logic        rsp_cout, rsp_ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  addsub_rr_arbiter #(.WIDTH(4), .N_REQ(4), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_x(req_x), .req_y(req_y),
    .req_add_n(req_add_n), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [3:0] x, input logic [3:0] y, input logic sub);
    req_x[i*4 +: 4] = x;
    req_y[i*4 +: 4] = y;
    req_add_n[i]    = sub;
  endtask

  // Drive req at the falling edge, check the combinational grant, then step past the rising edge.
  task automatic issue(input string tag, input logic [3:0] r, input logic [3:0] egnt);
    @(negedge clk);
    req = r;
    #1;
    chk({tag, ".gnt"}, 32'(gnt), 32'(egnt));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string tag, input logic [1:0] id, input logic [3:0] res,
                         input logic cout, input logic ovf);
    chk({tag, ".valid"},  32'(rsp_valid),  32'd1);
    chk({tag, ".id"},     32'(rsp_id),     32'(id));
    chk({tag, ".result"}, 32'(rsp_result), 32'(res));
    chk({tag, ".cout"},   32'(rsp_cout),   32'(cout));
    chk({tag, ".ovf"},    32'(rsp_ovf),    32'(ovf));
  endtask

  initial begin
    logic [3:0] rr_gnt [5];
    logic [1:0] rr_id  [5];
    rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    rst_n = 1'b0; req = 4'b1111; req_x = '0; req_y = '0; req_add_n = '0; rsp_ready = 1'b1;
    #1;
    chk("rst.gnt",    32'(gnt),        32'd0);
    #20;
    chk("rst.valid",  32'(rsp_valid),  32'd0);
    chk("rst.id",     32'(rsp_id),     32'd0);
    chk("rst.result", 32'(rsp_result), 32'd0);
    chk("rst.cout",   32'(rsp_cout),   32'd0);
    chk("rst.ovf",    32'(rsp_ovf),    32'd0);
    @(negedge clk);
    req = 4'b0000;
    rst_n = 1'b1;

    // Test 1: single add on requester 2
    set_op(2, 4'd5, 4'd3, 1'b0);
    issue("t1", 4'b0100, 4'b0100);
    chk_rsp("t1", 2'd2, 4'h8, 1'b0, 1'b1);
    req = 4'b0000;

    // Test 2: subtracts, ptr starts at 3
    set_op(3, 4'd3, 4'd5, 1'b1);
    issue("t2a", 4'b1000, 4'b1000);
    chk_rsp("t2a", 2'd3, 4'hE, 1'b0, 1'b0);
    req = 4'b0000;
    set_op(0, 4'd5, 4'd3, 1'b1);
    issue("t2b", 4'b0001, 4'b0001);
    chk_rsp("t2b", 2'd0, 4'h2, 1'b1, 1'b0);
    req = 4'b0000;
    set_op(1, 4'd8, 4'd1, 1'b1);
    issue("t2c", 4'b0010, 4'b0010);
    chk_rsp("t2c", 2'd1, 4'h7, 1'b1, 1'b1);
    req = 4'b0000;
    // ptr = 2; move it to 0 via requester 3 (ptr 2 scan: 3 first)
    set_op(3, 4'd1, 4'd1, 1'b0);
    issue("t2d", 4'b1000, 4'b1000);
    chk_rsp("t2d", 2'd3, 4'h2, 1'b0, 1'b0);

    // Test 3: all requesting, back-to-back round robin; operand x=i+1, y=2
    for (int i = 0; i < 4; i++) set_op(i, 4'(i + 1), 4'd2, 1'b0);
    for (int n = 0; n < 5; n++) begin
      issue($sformatf("t3.%0d", n), 4'b1111, rr_gnt[n]);
      chk_rsp($sformatf("t3.%0d", n), rr_id[n], 4'(int'(rr_id[n]) + 3), 1'b0, 1'b0);
    end

    // Test 4: back-pressure, ptr = 1
    @(negedge clk);
    rsp_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      chk($sformatf("t4.gnt%0d", n), 32'(gnt), 32'd0);
      @(posedge clk);
      #1;
      chk_rsp($sformatf("t4.hold%0d", n), 2'd0, 4'h3, 1'b0, 1'b0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    chk("t4.resume_gnt", 32'(gnt), 32'b0010);
    @(posedge clk);
    #1;
    chk_rsp("t4.resume", 2'd1, 4'h4, 1'b0, 1'b0);

    // Test 5: ptr = 2 -> requester 2 moves it to 3
    issue("t5a", 4'b0100, 4'b0100);
    issue("t5b", 4'b0011, 4'b0001);
    chk_rsp("t5b", 2'd0, 4'h3, 1'b0, 1'b0);
    issue("t5c", 4'b0011, 4'b0010);
    chk_rsp("t5c", 2'd1, 4'h4, 1'b0, 1'b0);
    issue("t5d", 4'b0001, 4'b0001);
    chk_rsp("t5d", 2'd0, 4'h3, 1'b0, 1'b0);

    // Test 6: reset with a pending response
    @(negedge clk);
    rsp_ready = 1'b0;
    req = 4'b1010;
    rst_n = 1'b0;
    #1;
    chk("t6.valid", 32'(rsp_valid), 32'd0);
    chk("t6.gnt",   32'(gnt),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("t6.first_gnt", 32'(gnt), 32'b0010);
    @(posedge clk);
    #1;
    chk_rsp("t6.rsp", 2'd1, 4'h4, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
